// File: rtl/sram_like_responder_if.sv
// sram-like data bus between a requester (master) and the responder memory (slave).
// QDEPTH sizes the outstanding-request counter and must match the responder's QDEPTH.
interface sram_like_responder_if #(
   parameter int QDEPTH = 4
);
   localparam int CNT_W = $clog2(QDEPTH) + 1;

   logic             data_req;
   logic             data_wr;
   logic [1:0]       data_size;
   logic [31:0]      data_addr;
   logic [31:0]      data_wdata;
   logic [3:0]       data_wstrb;
   logic [31:0]      data_rdata;
   logic             data_addr_ok;
   logic             data_data_ok;
   logic [CNT_W-1:0] outstanding;

   modport master (
      output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      input  data_rdata, data_addr_ok, data_data_ok, outstanding
   );

   modport slave (
      input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
      output data_rdata, data_addr_ok, data_data_ok, outstanding
   );
endinterface

// File: rtl/sram_like_responder.sv
// Responder end of the sram-like data bus, backed by a word-addressed RAM, in-order completions.
// Optional feature: define RESP_STALL_EN to inject LFSR-driven accept/complete stalls.
module sram_like_responder #(
   parameter int MEM_AW  = 10,
   parameter int QDEPTH  = 4,
   parameter int LATENCY = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   sram_like_responder_if.slave bus
);

   localparam int PTR_W     = $clog2(QDEPTH);
   localparam int CNT_W     = PTR_W + 1;
   localparam int AGE_W     = $clog2(LATENCY + 1);
   localparam int READY_AGE = (LATENCY >= 2) ? LATENCY - 2 : 0;

   logic [31:0]       mem [2**MEM_AW];
   logic [MEM_AW-1:0] wordIdx;
   logic              full;
   logic              accept;
   logic              stallAccept;
   logic              stallRetire;

   logic              entryRead_q [QDEPTH];
   logic [31:0]       entryData_q [QDEPTH];
   logic [AGE_W-1:0]  entryAge_q  [QDEPTH];

   logic [PTR_W-1:0]  headPtr_q, headPtr_d;
   logic [PTR_W-1:0]  tailPtr_q, tailPtr_d;
   logic [CNT_W-1:0]  outCnt_q, outCnt_d;
   logic              dataOk_q, dataOk_d;
   logic [PTR_W-1:0]  candPtr;
   logic [CNT_W-1:0]  remaining;

   logic unusedBits;
   assign unusedBits = ^{bus.data_size, bus.data_addr[31:MEM_AW+2], bus.data_addr[1:0]};

   assign wordIdx = bus.data_addr[MEM_AW+1:2];
   assign full    = (outCnt_q == CNT_W'(QDEPTH));

   // Full is judged on the registered count, so a same-cycle retire never frees a slot early.
   assign accept            = !rst && bus.data_req && !full && !stallAccept;
   assign bus.data_addr_ok  = accept;
   assign bus.data_data_ok  = dataOk_q;
   assign bus.outstanding   = outCnt_q;
   assign bus.data_rdata    = (dataOk_q && entryRead_q[headPtr_q]) ? entryData_q[headPtr_q] : 32'h0;

`ifdef RESP_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign stallAccept = lfsr_q[0];
   assign stallRetire = lfsr_q[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= 16'hACE1;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   assign stallAccept = 1'b0;
   assign stallRetire = 1'b0;
`endif

   // RAM is deliberately not reset, so accepted writes survive a mid-operation reset.
   always_ff @(posedge clk) begin
      if (accept && bus.data_wr) begin
         for (int b = 0; b < 4; b++) begin
            if (bus.data_wstrb[b]) begin
               mem[wordIdx][8*b +: 8] <= bus.data_wdata[8*b +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < QDEPTH; i++) begin
         if (entryAge_q[i] != AGE_W'(LATENCY)) begin
            entryAge_q[i] <= entryAge_q[i] + 1'b1;
         end
      end
      if (accept) begin
         entryRead_q[tailPtr_q] <= !bus.data_wr;
         entryData_q[tailPtr_q] <= bus.data_wr ? 32'h0 : mem[wordIdx];
         entryAge_q[tailPtr_q]  <= '0;
      end
   end

   // data_ok is decided one cycle ahead for whichever entry will be head next cycle;
   // an entry aged READY_AGE now has been accepted LATENCY-1 cycles ago.
   always_comb begin
      headPtr_d = headPtr_q;
      tailPtr_d = tailPtr_q;
      outCnt_d  = outCnt_q;
      dataOk_d  = 1'b0;
      remaining = outCnt_q;
      candPtr   = headPtr_q;

      if (dataOk_q) begin
         headPtr_d = headPtr_q + 1'b1;
         remaining = outCnt_q - 1'b1;
      end
      candPtr = headPtr_d;

      if (accept) begin
         tailPtr_d = tailPtr_q + 1'b1;
      end
      outCnt_d = remaining + CNT_W'(accept);

      if (remaining != '0) begin
         dataOk_d = (entryAge_q[candPtr] >= AGE_W'(READY_AGE));
      end else begin
         dataOk_d = accept && (LATENCY == 1);
      end

      if (stallRetire) begin
         dataOk_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         headPtr_q <= '0;
         tailPtr_q <= '0;
         outCnt_q  <= '0;
         dataOk_q  <= 1'b0;
      end else begin
         headPtr_q <= headPtr_d;
         tailPtr_q <= tailPtr_d;
         outCnt_q  <= outCnt_d;
         dataOk_q  <= dataOk_d;
      end
   end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench: a LATENCY=5 responder for write/read, strobe, full-queue and reset cases,
// and a LATENCY=1 responder for the back-to-back alternating write/read stream.
module tb_sram_like_responder;

   localparam int LOGN = 512;

   logic        clk = 1'b0;
   logic        rstSlow;
   logic        rstFast;
   int          cyc = 0;
   int          checkCount = 0;
   int          passCount = 0;

   logic        slowOk  [LOGN];
   logic [31:0] slowRd  [LOGN];
   logic [31:0] slowOut [LOGN];
   logic        fastOk  [LOGN];
   logic [31:0] fastRd  [LOGN];
   logic [31:0] fastOut [LOGN];

   sram_like_responder_if #(.QDEPTH(4)) slowBus ();
   sram_like_responder_if #(.QDEPTH(4)) fastBus ();

   sram_like_responder #(.MEM_AW(10), .QDEPTH(4), .LATENCY(5)) dutSlow (
      .clk (clk),
      .rst (rstSlow),
      .bus (slowBus)
   );

   sram_like_responder #(.MEM_AW(10), .QDEPTH(4), .LATENCY(1)) dutFast (
      .clk (clk),
      .rst (rstFast),
      .bus (fastBus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Outputs are logged mid-cycle, indexed by the cycle number the driver also sees.
   always @(negedge clk) begin
      if (cyc < LOGN) begin
         slowOk[cyc]  = slowBus.data_data_ok;
         slowRd[cyc]  = slowBus.data_rdata;
         slowOut[cyc] = 32'(slowBus.outstanding);
         fastOk[cyc]  = fastBus.data_data_ok;
         fastRd[cyc]  = fastBus.data_rdata;
         fastOut[cyc] = 32'(fastBus.outstanding);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
      end
   endtask

   function automatic logic [31:0] slowOkAt(input int c);
      if (c < 0 || c >= LOGN) return 32'hDEAD;
      return 32'(slowOk[c]);
   endfunction

   function automatic logic [31:0] slowRdAt(input int c);
      if (c < 0 || c >= LOGN) return 32'hDEAD;
      return slowRd[c];
   endfunction

   function automatic logic [31:0] slowOutAt(input int c);
      if (c < 0 || c >= LOGN) return 32'hDEAD;
      return slowOut[c];
   endfunction

   function automatic logic [31:0] fastOkAt(input int c);
      if (c < 0 || c >= LOGN) return 32'hDEAD;
      return 32'(fastOk[c]);
   endfunction

   function automatic logic [31:0] fastRdAt(input int c);
      if (c < 0 || c >= LOGN) return 32'hDEAD;
      return fastRd[c];
   endfunction

   function automatic logic [31:0] countSlowOk(input int lo, input int hi);
      int n = 0;
      for (int c = lo; c <= hi; c++) begin
         if (c >= 0 && c < LOGN && slowOk[c]) n++;
      end
      return 32'(n);
   endfunction

   // Holds a request on the slow bus until accepted; req stays high for back-to-back reuse.
   task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [3:0] wstrb, output int accCyc);
      accCyc = -1;
      @(posedge clk); #1;
      slowBus.data_req   = 1'b1;
      slowBus.data_wr    = wr;
      slowBus.data_size  = 2'd2;
      slowBus.data_addr  = addr;
      slowBus.data_wdata = wdata;
      slowBus.data_wstrb = wstrb;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (slowBus.data_addr_ok) begin
            accCyc = cyc;
            break;
         end
         @(posedge clk); #1;
      end
      if (accCyc < 0) checkOutput("acceptTimeout", 32'd0, 32'd1);
   endtask

   task automatic idleSlow(input int n);
      @(posedge clk); #1;
      slowBus.data_req = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int accW, accR, a0, a1, a2, rA, rB, rc, r3, f0;
      int acc [6];
      int done [6];
      logic [31:0] rdAddr, rdExp;

      for (int i = 0; i < LOGN; i++) begin
         slowOk[i] = 1'b0; slowRd[i] = '0; slowOut[i] = '0;
         fastOk[i] = 1'b0; fastRd[i] = '0; fastOut[i] = '0;
      end

      rstSlow = 1'b1;
      rstFast = 1'b1;
      slowBus.data_req   = 1'b1;
      slowBus.data_wr    = 1'b0;
      slowBus.data_size  = 2'd2;
      slowBus.data_addr  = 32'h100;
      slowBus.data_wdata = '0;
      slowBus.data_wstrb = '0;
      fastBus.data_req   = 1'b0;
      fastBus.data_wr    = 1'b0;
      fastBus.data_size  = 2'd2;
      fastBus.data_addr  = 32'h200;
      fastBus.data_wdata = '0;
      fastBus.data_wstrb = 4'hF;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rstAddrOk", 32'(slowBus.data_addr_ok), 32'd0);
      checkOutput("rstDataOk", 32'(slowBus.data_data_ok), 32'd0);
      checkOutput("rstRdata", slowBus.data_rdata, 32'd0);
      checkOutput("rstOutstanding", 32'(slowBus.outstanding), 32'd0);
      @(posedge clk); #1;
      rstSlow = 1'b0;
      rstFast = 1'b0;
      slowBus.data_req = 1'b0;

      // Full-word write then read of the same word.
      applyStimulus(1'b1, 32'h100, 32'h11223344, 4'hF, accW);
      applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, accR);
      idleSlow(8);
      checkOutput("t1BackToBack", 32'(accR - accW), 32'd1);
      checkOutput("t1WrNotEarly", slowOkAt(accW + 4), 32'd0);
      checkOutput("t1WrOk", slowOkAt(accW + 5), 32'd1);
      checkOutput("t1WrRdataZero", slowRdAt(accW + 5), 32'd0);
      checkOutput("t1RdOk", slowOkAt(accR + 5), 32'd1);
      checkOutput("t1RdData", slowRdAt(accR + 5), 32'h11223344);
      checkOutput("t1Drained", 32'(slowBus.outstanding), 32'd0);

      // Partial-strobe and zero-strobe writes.
      applyStimulus(1'b1, 32'h104, 32'h55667788, 4'hF, a0);
      applyStimulus(1'b1, 32'h104, 32'hAABBCCDD, 4'b0101, a1);
      applyStimulus(1'b0, 32'h104, 32'h0, 4'h0, rA);
      applyStimulus(1'b1, 32'h104, 32'hFFFFFFFF, 4'h0, a2);
      applyStimulus(1'b0, 32'h104, 32'h0, 4'h0, rB);
      idleSlow(10);
      checkOutput("t2StrobeOk", slowOkAt(rA + 5), 32'd1);
      checkOutput("t2StrobeData", slowRdAt(rA + 5), 32'h55BB77DD);
      checkOutput("t2ZeroStrbOk", slowOkAt(rB + 5), 32'd1);
      checkOutput("t2ZeroStrbData", slowRdAt(rB + 5), 32'h55BB77DD);

      // Six back-to-back reads fill the 4-deep queue.
      for (int i = 0; i < 6; i++) begin
         rdAddr = (i % 2 == 1) ? 32'h104 : 32'h100;
         applyStimulus(1'b0, rdAddr, 32'h0, 4'h0, acc[i]);
      end
      idleSlow(14);
      checkOutput("t3FirstFour", 32'(acc[3] - acc[0]), 32'd3);
      checkOutput("t3FullCount", slowOutAt(acc[0] + 4), 32'd4);
      checkOutput("t3FifthHeld", 32'(acc[4] - acc[0]), 32'd6);
      for (int i = 0; i < 6; i++) begin
         done[i] = acc[i] + 5;
         if (i > 0 && done[i] <= done[i-1]) done[i] = done[i-1] + 1;
         rdExp = (i % 2 == 1) ? 32'h55BB77DD : 32'h11223344;
         checkOutput("t3OrderOk", slowOkAt(done[i]), 32'd1);
         checkOutput("t3OrderData", slowRdAt(done[i]), rdExp);
      end
      checkOutput("t3OkCount", countSlowOk(acc[0], acc[0] + 20), 32'd6);

      // Reset with three requests outstanding.
      applyStimulus(1'b1, 32'h10C, 32'hCAFEF00D, 4'hF, a0);
      applyStimulus(1'b0, 32'h10C, 32'h0, 4'h0, a1);
      applyStimulus(1'b0, 32'h100, 32'h0, 4'h0, a2);
      @(posedge clk); #1;
      slowBus.data_req = 1'b0;
      rstSlow = 1'b1;
      rc = cyc;
      @(negedge clk);
      checkOutput("t4OutBeforeRst", 32'(slowBus.outstanding), 32'd3);
      @(posedge clk); #1;
      rstSlow = 1'b0;
      repeat (10) @(posedge clk);
      checkOutput("t4OutAfterRst", slowOutAt(rc + 1), 32'd0);
      checkOutput("t4NoDataOk", countSlowOk(rc + 1, rc + 10), 32'd0);
      applyStimulus(1'b0, 32'h10C, 32'h0, 4'h0, r3);
      idleSlow(8);
      checkOutput("t4WriteKeptOk", slowOkAt(r3 + 5), 32'd1);
      checkOutput("t4WriteKept", slowRdAt(r3 + 5), 32'hCAFEF00D);

      // LATENCY=1 alternating write/read stream on one address.
      f0 = -1;
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) begin
         fastBus.data_req   = 1'b1;
         fastBus.data_wr    = (i % 2 == 0);
         fastBus.data_addr  = 32'h200;
         fastBus.data_wdata = 32'hA5000000 + 32'(i);
         fastBus.data_wstrb = 4'hF;
         @(negedge clk);
         checkOutput("t5AddrOk", 32'(fastBus.data_addr_ok), 32'd1);
         if (i == 0) f0 = cyc;
         @(posedge clk); #1;
      end
      fastBus.data_req = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         checkOutput("t5OkEveryCycle", fastOkAt(f0 + 1 + i), 32'd1);
         if (i % 2 == 1) begin
            checkOutput("t5ReadPrevWrite", fastRdAt(f0 + 1 + i), 32'hA5000000 + 32'(i - 1));
         end
      end
      checkOutput("t5SteadyOutstanding", (f0 + 4 >= 0 && f0 + 4 < LOGN) ? fastOut[f0 + 4] : 32'hDEAD, 32'd1);
      checkOutput("t5NoExtraOk", fastOkAt(f0 + 9), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
